// File: rtl/sim_loc_walker_pkg.sv
// rtl/sim_loc_walker_pkg.sv - default frame geometry, cell width and walker state encoding
package sim_loc_walker_pkg;

  localparam int PIXELS_X = 640;
  localparam int PIXELS_Y = 480;
  localparam int X_bits   = 10;
  localparam int Y_bits   = 9;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    DRAIN = 2'd1,
    PARK  = 2'd2
  } walker_state_t;

endpackage

// File: rtl/sim_loc_walker_loc_delay_line.sv
// rtl/sim_loc_walker_loc_delay_line.sv - RD_LAT-deep valid/x/y shift register with synchronous clear
module loc_delay_line #(
  parameter int RD_LAT = 2,
  parameter int X_bits = 10,
  parameter int Y_bits = 9
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [X_bits-1:0] in_x,
  input  logic [Y_bits-1:0] in_y,
  output logic              out_valid,
  output logic [X_bits-1:0] out_x,
  output logic [Y_bits-1:0] out_y
);

  logic [RD_LAT-1:0] vld;
  logic [X_bits-1:0] xs [RD_LAT];
  logic [Y_bits-1:0] ys [RD_LAT];

  // Never stalls: every read in flight completes RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      xs[0]  <= in_x;
      ys[0]  <= in_y;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        xs[i]  <= xs[i-1];
        ys[i]  <= ys[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_x     = xs[RD_LAT-1];
  assign out_y     = ys[RD_LAT-1];

endmodule

// File: rtl/sim_loc_walker.sv
// rtl/sim_loc_walker.sv - raster location walker feeding env cache reads and aligned cell output
// Optional SIM_LOC_FRAME_CNT_EN adds a 16-bit frame_count output.
module sim_loc_walker #(
  parameter int PIXELS_X = sim_loc_walker_pkg::PIXELS_X,
  parameter int PIXELS_Y = sim_loc_walker_pkg::PIXELS_Y,
  parameter int X_bits   = sim_loc_walker_pkg::X_bits,
  parameter int Y_bits   = sim_loc_walker_pkg::Y_bits,
  parameter int DATA_W   = sim_loc_walker_pkg::DATA_W,
  parameter int RD_LAT   = 2
) (
  input  logic              newLocClock,
  input  logic              Reset,
  input  logic              hold_locs,
  input  logic              write_flag,
  output logic [X_bits-1:0] readLoc_x,
  output logic [Y_bits-1:0] readLoc_y,
  output logic              read_en,
  input  logic [DATA_W-1:0] env_rd_data,
  output logic [X_bits-1:0] writeLoc_x,
  output logic [Y_bits-1:0] writeLoc_y,
  output logic [DATA_W-1:0] loc_data,
  output logic              loc_valid,
  output logic              write_en,
  output logic              frame_done
`ifdef SIM_LOC_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  import sim_loc_walker_pkg::*;

  localparam int IW = $clog2(RD_LAT + 1);
  localparam logic [X_bits-1:0] X_LAST = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(PIXELS_Y - 1);

  walker_state_t     state;
  logic [X_bits-1:0] cnt_x;
  logic [Y_bits-1:0] cnt_y;
  logic [IW-1:0]     in_flight;
  logic              dl_valid;
  logic [X_bits-1:0] dl_x;
  logic [Y_bits-1:0] dl_y;

  assign read_en   = !Reset && (state == ISSUE) && !hold_locs;
  assign readLoc_x = cnt_x;
  assign readLoc_y = cnt_y;
  assign write_en  = loc_valid & write_flag;

  loc_delay_line #(
    .RD_LAT (RD_LAT),
    .X_bits (X_bits),
    .Y_bits (Y_bits)
  ) u_delay_line (
    .clk       (newLocClock),
    .clear     (Reset),
    .in_valid  (read_en),
    .in_x      (cnt_x),
    .in_y      (cnt_y),
    .out_valid (dl_valid),
    .out_x     (dl_x),
    .out_y     (dl_y)
  );

  always_ff @(posedge newLocClock) begin
    if (Reset) begin
      state <= ISSUE;
      cnt_x <= '0;
      cnt_y <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (read_en) begin
            if (cnt_x == X_LAST) begin
              cnt_x <= '0;
              cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + 1'b1;
            end else begin
              cnt_x <= cnt_x + 1'b1;
            end
            if (cnt_x == X_LAST && cnt_y == Y_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Park only once the botright cell has left the output register.
          if (in_flight == '0 && !loc_valid) state <= PARK;
        end
        PARK: begin
          if (!hold_locs) begin
            state <= ISSUE;
            cnt_x <= '0;
            cnt_y <= '0;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  always_ff @(posedge newLocClock) begin
    if (Reset) begin
      loc_valid  <= 1'b0;
      frame_done <= 1'b0;
      writeLoc_x <= '0;
      writeLoc_y <= '0;
      loc_data   <= '0;
      in_flight  <= '0;
    end else begin
      loc_valid  <= dl_valid;
      frame_done <= dl_valid && (dl_x == X_LAST) && (dl_y == Y_LAST);
      if (dl_valid) begin
        writeLoc_x <= dl_x;
        writeLoc_y <= dl_y;
        loc_data   <= env_rd_data;
      end
      case ({read_en, dl_valid})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

`ifdef SIM_LOC_FRAME_CNT_EN
  always_ff @(posedge newLocClock) begin
    if (Reset) frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 1'b1;
  end
`endif

endmodule

// File: doc/sim_loc_walker.md
Name: sim_loc_walker

Overview:
- Generates the raster location stream that drives the simulation-state controller's writeLoc_x/writeLoc_y inputs.
- Honours that controller's hold_locs.
- Issues read addresses to the environment cache and re-aligns the returned cell data with its location after a fixed read latency.
- Parks cleanly at frame end, so no location is lost or duplicated across hold/write boundaries.

Parameters:
- PIXELS_X, 640, horizontal locations per frame
- PIXELS_Y, 480, vertical locations per frame
- X_bits, 10, width of x coordinates
- Y_bits, 9, width of y coordinates
- DATA_W, 8, environment cell width
- RD_LAT, 2, env cache read latency in cycles (1..4)

Ports:
- newLocClock  in  1  sole clock
- Reset  in  1  synchronous, active-high reset
- hold_locs  in  1  from controller; 1 = do not start new locations
- write_flag  in  1  from controller; 1 = frame writes permitted
- readLoc_x  out  X_bits  env cache read x address
- readLoc_y  out  Y_bits  env cache read y address
- read_en  out  1  read issued this cycle
- env_rd_data  in  DATA_W  cache data, valid RD_LAT cycles after read_en
- writeLoc_x  out  X_bits  location of current output cell
- writeLoc_y  out  Y_bits  location of current output cell
- loc_data  out  DATA_W  cell data aligned with writeLoc
- loc_valid  out  1  writeLoc/loc_data updated this cycle
- write_en  out  1  loc_valid & write_flag
- frame_done  out  1  one-cycle pulse when the botright entry is output

Behaviour:
- Reset values: all outputs 0; issue counters at (0,0); state ISSUE; in-flight count 0; delay line cleared.
- Issue counter: x increments 0..PIXELS_X-1. On wrap, x goes to 0 and y increments. After (PIXELS_X-1, PIXELS_Y-1), both go to (0,0).
- read_en = 1 only in ISSUE with hold_locs = 0. readLoc is the counter value, combinational from the register. The counter advances on the same edge.
- Delay line: RD_LAT stages carrying {x, y, valid}. It is never stalled, because reads in flight always complete.
- Output register: on a stage-RD_LAT valid entry, capture writeLoc_x/y, env_rd_data into loc_data, and set loc_valid = 1 the next cycle. Otherwise loc_valid = 0 and writeLoc/loc_data hold their values.
- Latency: read_en at cycle T gives loc_valid at T+RD_LAT+1.
- write_en is combinational: loc_valid & write_flag.
- frame_done = loc_valid when writeLoc is botright.
- In-flight counter: +1 on read_en, -1 on a valid entry leaving the delay line; both in one cycle gives no change. Width covers 0..RD_LAT.

State machine:
- ISSUE:
  - Issue while hold_locs = 0.
  - hold_locs = 1 mid-frame pauses issuing; the counter is frozen and issuing resumes where it stopped.
  - Issuing (PIXELS_X-1, PIXELS_Y-1) moves to DRAIN.
- DRAIN: no issue. When in-flight = 0 and nothing is in the output register, move to PARK.
- PARK:
  - hold_locs = 0 moves to ISSUE from (0,0).
  - hold_locs = 1 stays in PARK. This covers the controller's WAIT states; the controller INIT→WRITE transition never asserts hold, so PARK lasts one cycle there.
- Exactly one botright output per frame. The controller sees botright for exactly one cycle while in INIT/WRITE.

Boundary conditions:
- Reset mid-frame flushes the delay line; in-flight data is discarded and never output.
- hold_locs toggling during DRAIN is ignored.
- PIXELS_X = 1 or PIXELS_Y = 1 must wrap correctly.

Optional Feature:
- Macro: SIM_LOC_FRAME_CNT_EN.
- When defined: adds output frame_count [15:0]. It resets to 0, increments on each frame_done, and wraps at 65535→0.
- When undefined: the port is absent and no counter logic is generated.

Decomposition:
- Shared package params.sv holds PIXELS_X, PIXELS_Y, X_bits, Y_bits, DATA_W and the walker state enum (ISSUE, DRAIN, PARK).
- One natural sub-module, loc_delay_line: an RD_LAT-deep valid/x/y shift register with synchronous clear.

Test Plan:
- Reset released, hold_locs = 0, PIXELS_X = 4, PIXELS_Y = 3, RD_LAT = 2 → read_en for 12 consecutive cycles covering (0,0)..(3,2). loc_valid first at cycle 3 with writeLoc (0,0). frame_done with (3,2). PARK → ISSUE restarts at (0,0).
- Memory model returns x+4y → every loc_valid has loc_data = writeLoc_x + 4·writeLoc_y. No gaps or repeats over 3 frames.
- hold_locs = 1 for 5 cycles after issuing (1,1) → no read_en for 5 cycles. Pending outputs still emerge. Resume issues (2,1).
- Hold asserted the cycle after frame_done and held for 20 cycles → walker stays in PARK with read_en = 0. Release → next read is (0,0) within 1 cycle.
- write_flag = 0 during a frame → loc_valid pulses but write_en stays 0. write_flag = 1 → write_en equals loc_valid.
- Reset asserted with 2 reads in flight → no loc_valid afterward until new reads are issued; first output is (0,0). With SIM_LOC_FRAME_CNT_EN defined, frame_count = 0, then 1 after the next frame_done.
